// File: rtl/fm_in_video_write.sv
// Input-video frame-memory writer: packs 10-bit RGB pixels, buffers them in a FIFO and drains
// them into ping-pong frame banks during input-video write slots. Optional macro: FM_IV_WR_PIXCNT_EN.
module fm_in_video_write #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned BURST_LEN    = 8,
  parameter int unsigned FRAME_PIXELS = 61440
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vin_vs,
  input  logic        vin_de,
  input  logic [9:0]  vin_r,
  input  logic [9:0]  vin_g,
  input  logic [9:0]  vin_b,
  input  logic        fm_cycle_stp_adv,
  input  logic        fm_iv_wr_cycle,
  input  logic        ovf_clr,
  output logic        fm_iv_wr_en,
  output logic [16:0] fm_iv_wr_adrs,
  output logic [29:0] fm_iv_wr_d,
  output logic        frame_alt,
`ifdef FM_IV_WR_PIXCNT_EN
  output logic [16:0] frame_pixcnt,
`endif
  output logic        ovf
);

  localparam int unsigned AddrW     = $clog2(FIFO_DEPTH);
  localparam logic [6:0]  BurstLenW = 7'(BURST_LEN);
  localparam logic [16:0] FramePix  = 17'(FRAME_PIXELS);

  // FIFO storage: {sof, r, g, b}
  logic [30:0]      mem_q [FIFO_DEPTH];
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             full, empty;
  logic [30:0]      head;

  logic             vs_q;
  logic             vs_rise;
  logic             sof_pend_q, sof_pend_d;
  logic             sof_now;

  logic [6:0]       burst_cnt_q, burst_cnt_d;
  logic [6:0]       burst_eff;
  logic             push, pop, drop;

  logic             synced_q, synced_d;
  logic             bank_q, bank_d;
  logic             alt_q, alt_d;
  logic [16:0]      idx_q, idx_d;
  logic             wr_en_q, wr_en_d;
  logic [16:0]      adrs_q, adrs_d;
  logic [29:0]      data_q, data_d;
  logic             ovf_q, ovf_d;
  logic             ovf_set;
`ifdef FM_IV_WR_PIXCNT_EN
  logic [16:0]      pixcnt_q, pixcnt_d;
`endif

  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign head  = mem_q[rptr_q[AddrW-1:0]];

  // Push / pop control
  always_comb begin
    vs_rise   = vin_vs & ~vs_q;
    sof_now   = sof_pend_q | vs_rise;
    // A slot-start strobe restarts the burst budget in the same clk it arrives.
    burst_eff = fm_cycle_stp_adv ? 7'd0 : burst_cnt_q;
    pop       = fm_iv_wr_cycle & ~empty & (burst_eff < BurstLenW);
    push      = vin_de & (~full | pop);
    drop      = vin_de & full & ~pop;
    // A dropped sof pixel hands its flag to the next accepted push.
    sof_pend_d  = sof_now & ~push;
    burst_cnt_d = pop ? burst_eff + 7'd1 : burst_eff;
    wptr_d      = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = pop ? rptr_q + 1'b1 : rptr_q;
  end

  // Write path and frame bookkeeping
  always_comb begin
    wr_en_d  = 1'b0;
    adrs_d   = adrs_q;
    data_d   = data_q;
    synced_d = synced_q;
    bank_d   = bank_q;
    alt_d    = alt_q;
    idx_d    = idx_q;
    ovf_set  = drop;
`ifdef FM_IV_WR_PIXCNT_EN
    pixcnt_d = pixcnt_q;
`endif
    if (pop) begin
      if (head[30]) begin
        wr_en_d = 1'b1;
        data_d  = head[29:0];
        idx_d   = 17'd1;
        if (synced_q) begin
          alt_d  = bank_q;
          bank_d = ~bank_q;
          adrs_d = {~bank_q, 16'h0000};
`ifdef FM_IV_WR_PIXCNT_EN
          pixcnt_d = idx_q;
`endif
        end else begin
          // First sof after reset: lock onto bank 0 without flipping.
          synced_d = 1'b1;
          adrs_d   = {bank_q, 16'h0000};
        end
      end else if (synced_q) begin
        if (idx_q == FramePix) begin
          ovf_set = 1'b1;
        end else begin
          wr_en_d = 1'b1;
          adrs_d  = {bank_q, idx_q[15:0]};
          data_d  = head[29:0];
          idx_d   = idx_q + 17'd1;
        end
      end
    end
    ovf_d = ovf_set | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= {sof_now, vin_r, vin_g, vin_b};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      vs_q        <= 1'b0;
      sof_pend_q  <= 1'b0;
      burst_cnt_q <= '0;
      synced_q    <= 1'b0;
      bank_q      <= 1'b0;
      alt_q       <= 1'b1;
      idx_q       <= '0;
      wr_en_q     <= 1'b0;
      adrs_q      <= '0;
      data_q      <= '0;
      ovf_q       <= 1'b0;
`ifdef FM_IV_WR_PIXCNT_EN
      pixcnt_q    <= '0;
`endif
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      vs_q        <= vin_vs;
      sof_pend_q  <= sof_pend_d;
      burst_cnt_q <= burst_cnt_d;
      synced_q    <= synced_d;
      bank_q      <= bank_d;
      alt_q       <= alt_d;
      idx_q       <= idx_d;
      wr_en_q     <= wr_en_d;
      adrs_q      <= adrs_d;
      data_q      <= data_d;
      ovf_q       <= ovf_d;
`ifdef FM_IV_WR_PIXCNT_EN
      pixcnt_q    <= pixcnt_d;
`endif
    end
  end

  assign fm_iv_wr_en   = wr_en_q;
  assign fm_iv_wr_adrs = adrs_q;
  assign fm_iv_wr_d    = data_q;
  assign frame_alt     = alt_q;
  assign ovf           = ovf_q;
`ifdef FM_IV_WR_PIXCNT_EN
  assign frame_pixcnt  = pixcnt_q;
`endif

endmodule

// File: tb/tb_fm_in_video_write.sv
// Directed bench for fm_in_video_write: a default instance plus a FRAME_PIXELS=4 instance
// driven by the same stimulus.
module tb_fm_in_video_write;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vin_vs, vin_de;
  logic [9:0]  vin_r, vin_g, vin_b;
  logic        fm_cycle_stp_adv, fm_iv_wr_cycle, ovf_clr;

  logic        wr_en, s_wr_en;
  logic [16:0] wr_adrs, s_wr_adrs;
  logic [29:0] wr_d, s_wr_d;
  logic        alt, s_alt;
  logic        ovf, s_ovf;
`ifdef FM_IV_WR_PIXCNT_EN
  logic [16:0] pixcnt, s_pixcnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] wq_adrs[$];
  logic [29:0] wq_d[$];
  logic        wq_alt[$];
  logic [16:0] sq_adrs[$];

  always #5 clk = ~clk;

  fm_in_video_write dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .vin_vs           (vin_vs),
    .vin_de           (vin_de),
    .vin_r            (vin_r),
    .vin_g            (vin_g),
    .vin_b            (vin_b),
    .fm_cycle_stp_adv (fm_cycle_stp_adv),
    .fm_iv_wr_cycle   (fm_iv_wr_cycle),
    .ovf_clr          (ovf_clr),
    .fm_iv_wr_en      (wr_en),
    .fm_iv_wr_adrs    (wr_adrs),
    .fm_iv_wr_d       (wr_d),
    .frame_alt        (alt),
`ifdef FM_IV_WR_PIXCNT_EN
    .frame_pixcnt     (pixcnt),
`endif
    .ovf              (ovf)
  );

  fm_in_video_write #(
    .FRAME_PIXELS (4)
  ) dut_small (
    .clk              (clk),
    .rst_n            (rst_n),
    .vin_vs           (vin_vs),
    .vin_de           (vin_de),
    .vin_r            (vin_r),
    .vin_g            (vin_g),
    .vin_b            (vin_b),
    .fm_cycle_stp_adv (fm_cycle_stp_adv),
    .fm_iv_wr_cycle   (fm_iv_wr_cycle),
    .ovf_clr          (ovf_clr),
    .fm_iv_wr_en      (s_wr_en),
    .fm_iv_wr_adrs    (s_wr_adrs),
    .fm_iv_wr_d       (s_wr_d),
    .frame_alt        (s_alt),
`ifdef FM_IV_WR_PIXCNT_EN
    .frame_pixcnt     (s_pixcnt),
`endif
    .ovf              (s_ovf)
  );

  // Log every write word away from the active edge.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      wq_adrs.push_back(wr_adrs);
      wq_d.push_back(wr_d);
      wq_alt.push_back(alt);
    end
    if (s_wr_en === 1'b1) sq_adrs.push_back(s_wr_adrs);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    wq_adrs.delete();
    wq_d.delete();
    wq_alt.delete();
    sq_adrs.delete();
  endtask

  task automatic vs_pulse();
    vin_vs = 1'b1;
    tick();
    vin_vs = 1'b0;
  endtask

  task automatic slot_start();
    fm_iv_wr_cycle   = 1'b1;
    fm_cycle_stp_adv = 1'b1;
    tick();
    fm_cycle_stp_adv = 1'b0;
  endtask

  task automatic push_px(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    vin_de = 1'b1;
    vin_r  = r;
    vin_g  = g;
    vin_b  = b;
    tick();
    vin_de = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    vin_vs = 1'b0; vin_de = 1'b0;
    vin_r = '0; vin_g = '0; vin_b = '0;
    fm_cycle_stp_adv = 1'b0; fm_iv_wr_cycle = 1'b0; ovf_clr = 1'b0;
    tick(3);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_adrs", {15'd0, wr_adrs}, 32'd0);
    check("rst_d", {2'd0, wr_d}, 32'd0);
    check("rst_alt", {31'd0, alt}, 32'd1);
    check("rst_ovf", {31'd0, ovf}, 32'd0);
`ifdef FM_IV_WR_PIXCNT_EN
    check("rst_pixcnt", {15'd0, pixcnt}, 32'd0);
`endif
    rst_n = 1'b1;
    tick(2);

    // 1: first frame
    clear_logs();
    slot_start();
    vs_pulse();
    for (int i = 0; i < 4; i++) push_px(10'h3FF, 10'h155, 10'h0AA);
    tick(4);
    check("t1_count", wq_adrs.size(), 32'd4);
    check("t1_adrs0", {15'd0, wq_adrs[0]}, 32'h00000);
    check("t1_adrs3", {15'd0, wq_adrs[3]}, 32'h00003);
    check("t1_d0", {2'd0, wq_d[0]}, {2'd0, 10'h3FF, 10'h155, 10'h0AA});
    check("t1_alt", {31'd0, alt}, 32'd1);

    // 2: bank flip
    clear_logs();
    slot_start();
    vs_pulse();
    push_px(10'h001, 10'h002, 10'h003);
    push_px(10'h004, 10'h005, 10'h006);
    tick(4);
    check("t2_count", wq_adrs.size(), 32'd2);
    check("t2_adrs0", {15'd0, wq_adrs[0]}, 32'h10000);
    check("t2_alt_at_wr", {31'd0, wq_alt[0]}, 32'd0);
    check("t2_adrs1", {15'd0, wq_adrs[1]}, 32'h10001);
    check("t2_d1", {2'd0, wq_d[1]}, {2'd0, 10'h004, 10'h005, 10'h006});
`ifdef FM_IV_WR_PIXCNT_EN
    check("t2_pixcnt", {15'd0, pixcnt}, 32'd4);
`endif

    // 3: burst limit
    fm_iv_wr_cycle = 1'b0;
    tick();
    clear_logs();
    for (int i = 0; i < 12; i++) push_px(10'd0, 10'd0, 10'(i));
    tick(2);
    check("t3_no_wr_outside_slot", wq_adrs.size(), 32'd0);
    slot_start();
    tick(12);
    fm_iv_wr_cycle = 1'b0;
    tick(2);
    check("t3_burst_count", wq_adrs.size(), 32'd8);
    check("t3_burst_first", {15'd0, wq_adrs[0]}, 32'h10002);
    check("t3_burst_last", {15'd0, wq_adrs[7]}, 32'h10009);
    slot_start();
    tick(8);
    fm_iv_wr_cycle = 1'b0;
    tick(2);
    check("t3_total", wq_adrs.size(), 32'd12);
    check("t3_last_adrs", {15'd0, wq_adrs[11]}, 32'h1000D);
    check("t3_last_d", {2'd0, wq_d[11]}, 32'd11);

    // 4: FIFO overflow
    clear_logs();
    check("t4_ovf_pre", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 20; i++) push_px(10'd0, 10'd0, 10'(i));
    check("t4_ovf_set", {31'd0, ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", {31'd0, ovf}, 32'd0);
    ovf_clr = 1'b1;
    push_px(10'd0, 10'd0, 10'd99);
    ovf_clr = 1'b0;
    check("t4_set_wins", {31'd0, ovf}, 32'd1);
    slot_start();
    tick(10);
    slot_start();
    tick(10);
    fm_iv_wr_cycle = 1'b0;
    tick(2);
    check("t4_drained", wq_adrs.size(), 32'd16);
    check("t4_first_d", {2'd0, wq_d[0]}, 32'd0);
    check("t4_last_d", {2'd0, wq_d[15]}, 32'd15);

    // 5: frame overrun on the FRAME_PIXELS=4 instance
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t5_ovf_pre", {31'd0, s_ovf}, 32'd0);
    clear_logs();
    slot_start();
    vs_pulse();
    for (int i = 0; i < 6; i++) push_px(10'd1, 10'd1, 10'(i));
    tick(4);
    check("t5_count", sq_adrs.size(), 32'd4);
    check("t5_adrs0", {15'd0, sq_adrs[0]}, 32'h00000);
    check("t5_adrs3", {15'd0, sq_adrs[3]}, 32'h00003);
    check("t5_ovf", {31'd0, s_ovf}, 32'd1);
    check("t5_alt", {31'd0, s_alt}, 32'd1);
    sq_adrs.delete();
    slot_start();
    vs_pulse();
    push_px(10'd2, 10'd2, 10'd2);
    tick(3);
    check("t5_next_count", sq_adrs.size(), 32'd1);
    check("t5_next_adrs", {15'd0, sq_adrs[0]}, 32'h10000);
    check("t5_next_alt", {31'd0, s_alt}, 32'd0);

    // 6: mid-slot reset
    fm_iv_wr_cycle = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) push_px(10'd3, 10'd3, 10'(i));
    slot_start();
    tick(2);
    #2;
    check("t6_en_pre", {31'd0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_en_async", {31'd0, wr_en}, 32'd0);
    check("t6_adrs_async", {15'd0, wr_adrs}, 32'd0);
    check("t6_alt_async", {31'd0, alt}, 32'd1);
    check("t6_ovf_async", {31'd0, ovf}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick();
    clear_logs();
    slot_start();
    for (int i = 0; i < 3; i++) push_px(10'd4, 10'd4, 10'(i));
    tick(4);
    check("t6_no_presof_wr", wq_adrs.size(), 32'd0);
    vs_pulse();
    push_px(10'd5, 10'd6, 10'd7);
    tick(3);
    check("t6_sof_count", wq_adrs.size(), 32'd1);
    check("t6_sof_adrs", {15'd0, wq_adrs[0]}, 32'h00000);
    check("t6_sof_d", {2'd0, wq_d[0]}, {2'd0, 10'd5, 10'd6, 10'd7});
    check("t6_alt", {31'd0, alt}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
